// File: rtl/ccd_timing_pkg.sv
// Shared types and phase-pattern constants for the CCD horizontal timing generator.
// Pattern constants hold the level for phase n in bit n.
package ccd_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TRAIL  = 2'd3
    } ccd_state_t;

    typedef struct packed {
        logic h1;
        logic h2;
        logic rg;
        logic shp;
        logic shd;
    } ccd_out_t;

    localparam logic [3:0] H1_PAT  = 4'b0011;
    localparam logic [3:0] H2_PAT  = 4'b1100;
    localparam logic [3:0] RG_PAT  = 4'b0001;
    localparam logic [3:0] SHP_PAT = 4'b0010;
    localparam logic [3:0] SHD_PAT = 4'b1000;

    localparam ccd_out_t IDLE_OUT = '{h1: 1'b1, h2: 1'b0, rg: 1'b0, shp: 1'b0, shd: 1'b0};

endpackage

// File: rtl/ccd_hphase_decode.sv
// Combinational (state, phase) to CCD/AFE level decode; the parent registers the result.
module ccd_hphase_decode
    import ccd_timing_pkg::*;
(
    input  ccd_state_t state,
    input  logic [1:0] phase,
    output ccd_out_t   pat,
    output logic       pix_strobe
);

    always_comb begin
        pat        = IDLE_OUT;
        pix_strobe = 1'b0;
        if (state != ST_IDLE) begin
            pat.h1     = H1_PAT[phase];
            pat.h2     = H2_PAT[phase];
            pat.rg     = RG_PAT[phase];
            pat.shp    = SHP_PAT[phase];
            pat.shd    = SHD_PAT[phase];
            // Active pixel data is captured on the shd phase.
            pix_strobe = (state == ST_ACTIVE) && (phase == 2'd3);
        end
    end

endmodule

// File: rtl/ccd_htiming_gen.sv
// Horizontal CCD line sequencer: LEAD/ACTIVE/TRAIL pixels of 4 clocks each,
// with registered h1/h2/rg/shp/shd, active-pixel strobe/index and line handshake.
module ccd_htiming_gen
    import ccd_timing_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] lead_cnt,
    input  logic [CNT_W-1:0] active_cnt,
    input  logic [CNT_W-1:0] trail_cnt,
    output logic             busy,
    output logic             h1,
    output logic             h2,
    output logic             rg,
    output logic             shp,
    output logic             shd,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_idx,
    output logic             line_done
);

    ccd_state_t       state;
    ccd_state_t       entry_state;
    ccd_state_t       adv_state;
    logic [1:0]       phase;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] entry_cnt;
    logic [CNT_W-1:0] adv_cnt;
    logic [CNT_W-1:0] active_q;
    logic [CNT_W-1:0] trail_q;
    logic [CNT_W-1:0] act_idx;
    logic             accept;
    ccd_out_t         dec_pat;
    logic             dec_strobe;

    function automatic ccd_state_t first_state(input logic l_nz, input logic a_nz, input logic t_nz);
        if (l_nz)      return ST_LEAD;
        else if (a_nz) return ST_ACTIVE;
        else if (t_nz) return ST_TRAIL;
        else           return ST_IDLE;
    endfunction

    assign accept = (state == ST_IDLE) && start && !abort;

    always_comb begin
        entry_state = first_state(|lead_cnt, |active_cnt, |trail_cnt);
        case (entry_state)
            ST_LEAD:   entry_cnt = lead_cnt;
            ST_ACTIVE: entry_cnt = active_cnt;
            ST_TRAIL:  entry_cnt = trail_cnt;
            default:   entry_cnt = '0;
        endcase

        case (state)
            ST_LEAD:   adv_state = first_state(1'b0, |active_q, |trail_q);
            ST_ACTIVE: adv_state = first_state(1'b0, 1'b0, |trail_q);
            default:   adv_state = ST_IDLE;
        endcase
        case (adv_state)
            ST_ACTIVE: adv_cnt = active_q;
            ST_TRAIL:  adv_cnt = trail_q;
            default:   adv_cnt = '0;
        endcase
    end

    // Control stage: state, phase, remaining pixels in the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= 2'd0;
            rem       <= '0;
            busy      <= 1'b0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    state     <= entry_state;
                    phase     <= 2'd0;
                    rem       <= entry_cnt;
                    busy      <= (entry_state != ST_IDLE);
                    line_done <= (entry_state == ST_IDLE);
                end
            end else if (abort) begin
                state <= ST_IDLE;
                phase <= 2'd0;
                busy  <= 1'b0;
            end else begin
                phase <= phase + 2'd1;
                if (phase == 2'd3) begin
                    // Count down to 1 rather than 0 so a full-scale count never wraps.
                    if (rem == CNT_W'(1)) begin
                        state <= adv_state;
                        rem   <= adv_cnt;
                        if (adv_state == ST_IDLE) begin
                            busy      <= 1'b0;
                            line_done <= 1'b1;
                        end
                    end else begin
                        rem <= rem - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            active_q <= active_cnt;
            trail_q  <= trail_cnt;
            act_idx  <= '0;
        end else if (dec_strobe) begin
            act_idx <= act_idx + CNT_W'(1);
        end
    end

    ccd_hphase_decode u_decode (
        .state      (state),
        .phase      (phase),
        .pat        (dec_pat),
        .pix_strobe (dec_strobe)
    );

    // Output stage: one-clock registered decode of (state, phase).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h1        <= IDLE_OUT.h1;
            h2        <= IDLE_OUT.h2;
            rg        <= IDLE_OUT.rg;
            shp       <= IDLE_OUT.shp;
            shd       <= IDLE_OUT.shd;
            pix_valid <= 1'b0;
            pix_idx   <= '0;
        end else begin
            h1        <= dec_pat.h1;
            h2        <= dec_pat.h2;
            rg        <= dec_pat.rg;
            shp       <= dec_pat.shp;
            shd       <= dec_pat.shd;
            pix_valid <= dec_strobe;
            if (dec_strobe) pix_idx <= act_idx;
        end
    end

endmodule

// File: tb/tb_ccd_htiming_gen.sv
// Bench for ccd_htiming_gen: cycle-by-cycle comparison against a line-position model,
// plus hand-computed literal expectations for each directed scenario.
module tb_ccd_htiming_gen;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] lead_cnt;
    logic [CNT_W-1:0] active_cnt;
    logic [CNT_W-1:0] trail_cnt;
    logic             busy, h1, h2, rg, shp, shd, pix_valid, line_done;
    logic [CNT_W-1:0] pix_idx;

    ccd_htiming_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .lead_cnt   (lead_cnt),
        .active_cnt (active_cnt),
        .trail_cnt  (trail_cnt),
        .busy       (busy),
        .h1         (h1),
        .h2         (h2),
        .rg         (rg),
        .shp        (shp),
        .shd        (shd),
        .pix_valid  (pix_valid),
        .pix_idx    (pix_idx),
        .line_done  (line_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Tallies of DUT activity, cleared by the driver per scenario.
    int busy_cnt, pv_cnt, done_cnt, last_idx;

    // Model: a line is a window of 4*N busy cycles starting at m_t0; outputs show
    // the spec table for the position held one cycle earlier.
    bit m_known = 0, m_on = 0, m_prev_busy = 0, m_rst_prev = 0;
    int m_t0 = 0, m_len = 0, m_L = 0, m_A = 0, m_done_at = -1, m_prev_k = 0;
    bit e_busy, e_done, e_h1, e_h2, e_rg, e_shp, e_shd, e_pv;
    int e_idx, ph, px, n_tot;

    always @(negedge clk) begin
        e_busy = 1'b0;
        if (m_known) begin
            e_busy = m_on && (cyc >= m_t0) && (cyc < m_t0 + m_len);
            e_done = (cyc == m_done_at);
            e_idx  = 0;
            if (m_prev_busy) begin
                ph    = m_prev_k % 4;
                px    = m_prev_k / 4;
                e_h1  = (ph < 2);
                e_h2  = (ph >= 2);
                e_rg  = (ph == 0);
                e_shp = (ph == 1);
                e_shd = (ph == 3);
                e_pv  = (ph == 3) && (px >= m_L) && (px < m_L + m_A);
                e_idx = px - m_L;
            end else begin
                e_h1 = 1'b1; e_h2 = 1'b0; e_rg = 1'b0; e_shp = 1'b0; e_shd = 1'b0; e_pv = 1'b0;
            end
            chk("busy", busy, e_busy);
            chk("line_done", line_done, e_done);
            chk("h1", h1, e_h1);
            chk("h2", h2, e_h2);
            chk("rg", rg, e_rg);
            chk("shp", shp, e_shp);
            chk("shd", shd, e_shd);
            chk("pix_valid", pix_valid, e_pv);
            if (e_pv) chk("pix_idx", pix_idx, e_idx);
            if (m_rst_prev) chk("pix_idx_after_reset", pix_idx, 0);
            if (busy === 1'b1) busy_cnt++;
            if (line_done === 1'b1) done_cnt++;
            if (pix_valid === 1'b1) begin
                pv_cnt++;
                last_idx = int'(pix_idx);
            end
        end
        // Advance the model with the inputs sampled at the coming edge.
        m_prev_busy = e_busy;
        m_prev_k    = cyc - m_t0;
        m_rst_prev  = 1'b0;
        if (rst_n !== 1'b1) begin
            m_known     = 1'b1;
            m_on        = 1'b0;
            m_prev_busy = 1'b0;
            m_done_at   = -1;
            m_rst_prev  = 1'b1;
        end else if (e_busy && abort) begin
            m_on      = 1'b0;
            m_done_at = -1;
        end else if (!e_busy && start && !abort) begin
            n_tot = int'(lead_cnt) + int'(active_cnt) + int'(trail_cnt);
            if (n_tot == 0) begin
                m_done_at = cyc + 1;
            end else begin
                m_on      = 1'b1;
                m_t0      = cyc + 1;
                m_len     = 4 * n_tot;
                m_L       = int'(lead_cnt);
                m_A       = int'(active_cnt);
                m_done_at = cyc + 1 + m_len;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        busy_cnt = 0; pv_cnt = 0; done_cnt = 0; last_idx = -1;
    endtask

    task automatic go(input int l, input int a, input int t);
        lead_cnt   = CNT_W'(l);
        active_cnt = CNT_W'(a);
        trail_cnt  = CNT_W'(t);
        clr();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        lead_cnt = '0; active_cnt = '0; trail_cnt = '0;
        clr();
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_h1", h1, 1);
        chk("rst_h2", h2, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_idx", pix_idx, 0);
        chk("rst_line_done", line_done, 0);
        rst_n = 1'b1;
        tick(2);

        // Basic line 2/4/1.
        go(2, 4, 1);
        tick(30);
        chk("basic_busy_clocks", busy_cnt, 28);
        chk("basic_pix_count", pv_cnt, 4);
        chk("basic_last_idx", last_idx, 3);
        chk("basic_done_count", done_cnt, 1);

        // Single active pixel, phase table from T+2.
        go(0, 1, 0);
        tick(1);
        chk("ph0_h1", h1, 1); chk("ph0_h2", h2, 0); chk("ph0_rg", rg, 1);
        chk("ph0_shp", shp, 0); chk("ph0_shd", shd, 0);
        tick(1);
        chk("ph1_rg", rg, 0); chk("ph1_shp", shp, 1); chk("ph1_h1", h1, 1);
        tick(2);
        chk("ph3_shd", shd, 1); chk("ph3_pix_valid", pix_valid, 1);
        chk("ph3_pix_idx", pix_idx, 0); chk("ph3_h2", h2, 1); chk("ph3_line_done", line_done, 1);
        tick(1);
        chk("post_h1", h1, 1); chk("post_shd", shd, 0); chk("post_pix_valid", pix_valid, 0);
        tick(4);
        chk("single_busy_clocks", busy_cnt, 4);

        // Trail only.
        go(0, 0, 3);
        tick(16);
        chk("trail_busy_clocks", busy_cnt, 12);
        chk("trail_pix_count", pv_cnt, 0);
        chk("trail_done_count", done_cnt, 1);

        // All zero counts.
        go(0, 0, 0);
        chk("zero_line_done", line_done, 1);
        chk("zero_busy", busy, 0);
        tick(4);
        chk("zero_busy_clocks", busy_cnt, 0);
        chk("zero_done_count", done_cnt, 1);

        // Abort in ACTIVE together with start.
        go(1, 8, 2);
        tick(9);
        abort = 1'b1; start = 1'b1;
        lead_cnt = CNT_W'(0); active_cnt = CNT_W'(5); trail_cnt = CNT_W'(0);
        tick(1);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy_next", busy, 0);
        tick(1);
        chk("abort_idle_h1", h1, 1); chk("abort_idle_h2", h2, 0);
        chk("abort_idle_pix_valid", pix_valid, 0);
        tick(20);
        chk("abort_busy_clocks", busy_cnt, 10);
        chk("abort_done_count", done_cnt, 0);

        // Start pulsed mid-line is ignored.
        go(1, 2, 1);
        tick(3);
        lead_cnt = CNT_W'(5); active_cnt = CNT_W'(5); trail_cnt = CNT_W'(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        chk("ignore_busy_clocks", busy_cnt, 16);
        chk("ignore_pix_count", pv_cnt, 2);
        chk("ignore_done_count", done_cnt, 1);

        // Reset mid-line, then start in the first cycle out of reset.
        go(2, 3, 0);
        tick(8);
        rst_n = 1'b0;
        tick(1);
        chk("mrst_busy", busy, 0); chk("mrst_h1", h1, 1); chk("mrst_h2", h2, 0);
        chk("mrst_rg", rg, 0); chk("mrst_shp", shp, 0); chk("mrst_shd", shd, 0);
        chk("mrst_pix_valid", pix_valid, 0); chk("mrst_pix_idx", pix_idx, 0);
        chk("mrst_line_done", line_done, 0);
        chk("mrst_done_count", done_cnt, 0);
        rst_n = 1'b1;
        go(0, 2, 0);
        tick(12);
        chk("post_rst_busy_clocks", busy_cnt, 8);
        chk("post_rst_pix_count", pv_cnt, 2);
        chk("post_rst_done_count", done_cnt, 1);

        // Full-scale active count.
        go(0, 4095, 0);
        tick(4095 * 4 + 4);
        chk("max_pix_count", pv_cnt, 4095);
        chk("max_last_idx", last_idx, 4094);
        chk("max_busy_clocks", busy_cnt, 16380);
        chk("max_done_count", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ccd_htiming_gen.md
CCD_HTIMING_GEN -- requirements
Module: ccd_htiming_gen

Interface
REQ-001 Parameter CNT_W, default 12, width of all pixel counts and the pixel index.
REQ-002 clk  in  1  pixel-rate x4 clock (108 MHz 4X CCD clock); all logic on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 start  in  1  single-cycle request to clock out one line.
REQ-005 abort  in  1  synchronous abort of the line in progress.
REQ-006 lead_cnt  in  CNT_W  leading dummy pixels; latched on accepted start.
REQ-007 active_cnt  in  CNT_W  active pixels; latched on accepted start.
REQ-008 trail_cnt  in  CNT_W  trailing overscan pixels; latched on accepted start.
REQ-009 busy  out  1  high from the cycle after an accepted start until the line ends.
REQ-010 h1, h2  out  1 each  horizontal CCD register phases.
REQ-011 rg  out  1  reset gate pulse.
REQ-012 shp, shd  out  1 each  AFE reference and data sample strobes.
REQ-013 pix_valid  out  1  one-cycle strobe marking an active pixel's data sample.
REQ-014 pix_idx  out  CNT_W  active-pixel index; meaningful only while pix_valid is high.
REQ-015 line_done  out  1  one-cycle pulse at the end of a line.

Function
REQ-016 FSM states: IDLE, LEAD, ACTIVE, TRAIL. Each non-IDLE pixel spans 4 clocks, with phase counter values 0,1,2,3.
REQ-017 start shall be accepted only in IDLE.
  - Start while busy is ignored; no queuing.
  - Accepted start at cycle T: counts latched, phase=0, busy=1 at T+1.
REQ-018 Entry state on accepted start:
  - LEAD if lead_cnt>0;
  - else ACTIVE if active_cnt>0;
  - else TRAIL if trail_cnt>0;
  - else no state change: line_done pulses at T+1 and busy stays 0.
REQ-019 Each state runs for its latched pixel count, then advances to the next non-zero state in order LEAD->ACTIVE->TRAIL->IDLE, zero-count states skipped. The advance occurs on the clock after phase 3 of the state's last pixel.
REQ-020 Line length in busy clocks shall be 4*(lead_cnt+active_cnt+trail_cnt).
REQ-021 Phase pattern, in-line states (phase 0/1/2/3):
  - h1 = 1,1,0,0
  - h2 = 0,0,1,1
  - rg = 1,0,0,0
  - shp = 0,1,0,0
  - shd = 0,0,0,1
REQ-022 In IDLE: h1=1, h2=0, rg=0, shp=0, shd=0.
REQ-023 All CCD/AFE outputs shall be registered decodes of (state, phase), lagging by exactly 1 clock. The first phase-0 pattern is visible at T+2.
REQ-024 pix_valid shall be high on the same output cycle as shd, and only for ACTIVE pixels. pix_idx counts 0..active_cnt-1 and resets to 0 at each line start.
REQ-025 line_done shall pulse the cycle busy falls. It is aligned with the state register returning to IDLE, not with the delayed outputs.
REQ-026 abort, when sampled high in a non-IDLE state:
  - state forced to IDLE next cycle; busy=0 that cycle;
  - no line_done;
  - outputs reach idle levels one clock later.
REQ-027 abort has priority over start in the same cycle. abort in IDLE has no effect.
REQ-028 Counter arithmetic is CNT_W-bit unsigned with no wrap. A maximum count of 2^CNT_W-1 shall complete exactly.

Reset
REQ-029 While rst_n=0 at a clock edge:
  - state=IDLE, phase=0, pix_idx=0, busy=0, pix_valid=0, line_done=0;
  - h1=1, h2=0, rg=0, shp=0, shd=0.
REQ-030 Reset mid-line shall terminate the line with no line_done, identical to abort but taking effect at the same edge.
REQ-031 start sampled in the first cycle after rst_n returns high shall be accepted.

Structure
REQ-032 Package ccd_timing_pkg shall hold:
  - the state enum;
  - the 4-entry phase pattern constants for h1/h2/rg/shp/shd;
  - the idle output levels.
REQ-033 One sub-module, ccd_hphase_decode: combinational (state, phase) -> pattern decode, whose outputs are registered in the parent.

Verification
REQ-034 Basic line: lead=2, active=4, trail=1, start at T -> busy high for 28 clocks; 4 pix_valid pulses with pix_idx 0,1,2,3; line_done once.
REQ-035 Phase check: active=1 only -> h1/h2/rg/shp/shd match the REQ-021 table starting at T+2; pix_valid coincides with shd.
REQ-036 Zero counts: lead=0, active=0, trail=3 -> 12 busy clocks, no pix_valid. All counts zero -> line_done at T+1, busy never high.
REQ-037 Abort mid-ACTIVE with start asserted in the same cycle -> busy=0 next cycle, no line_done, no new line, idle output levels one clock later.
REQ-038 start pulsed while busy -> ignored; line length unchanged. rst_n low mid-line -> all outputs at reset values at the next edge.
REQ-039 Max count: active_cnt=4095 with CNT_W=12 -> 4095 pix_valid pulses, last pix_idx=4094, no wrap.
